// File: rtl/z80_io_pkg.sv
// Shared definitions for Z80 slave-side I/O ports: bus structs, register
// select encoding, status byte layout and the underrun fill byte.
package z80_io_pkg;

    // Bus structs shared with the output port and the address decoder.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        mreq_n;
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
        logic        m1_n;
    } Z80MasterBus;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;

    typedef enum logic {
        REG_DATA   = 1'b0,
        REG_STATUS = 1'b1
    } RegSelect;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_UNDERRUN  = 2;
    localparam int ST_COUNT_LSB = 3;

    localparam int         COUNT_W       = 5;
    localparam logic [7:0] UNDERRUN_FILL = 8'h00;

    // Status byte: {count[4:0], underrun, full, nonempty}.
    function automatic logic [7:0] packStatus(
        input logic [COUNT_W-1:0] count,
        input logic               underrun,
        input logic               full,
        input logic               nonempty
    );
        logic [7:0] s;
        s                              = 8'h00;
        s[ST_COUNT_LSB +: COUNT_W]     = count;
        s[ST_UNDERRUN]                 = underrun;
        s[ST_FULL]                     = full;
        s[ST_NONEMPTY]                 = nonempty;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and a 5-bit occupancy
// count; push while full and pop while empty are silently dropped.
module sync_fifo
    import z80_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      wr_ptr_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               doPush;
    logic               doPop;

    assign full   = (count_q == COUNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign rdata  = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (doPush) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (doPop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/iport.sv
// Z80 input port: a producer pushes bytes into a FIFO, the CPU pops them via
// the DATA register and polls occupancy/underrun via the STATUS register.
module iport
    import z80_io_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        sel,
    input  Z80MasterBus ibus,
    output Z80SlaveBus  obus,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready
);

    logic               ena_q;
    logic [7:0]         dslave_q;
    logic [7:0]         dslave_d;
    logic               underrun_q;
    logic               underrun_d;

    logic               access;
    logic               dataAccess;
    logic               statusAccess;
    logic               fifoPush;
    logic               fifoPop;
    logic [7:0]         fifoHead;
    logic [COUNT_W-1:0] fifoCount;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [7:0]         statusByte;
    logic               ibus_unused;

    // Read-only port: the master bus carries nothing this block acts on.
    assign ibus_unused = ^ibus;

    assign access       = ena & ~ena_q;
    assign dataAccess   = access & (sel == REG_DATA);
    assign statusAccess = access & (sel == REG_STATUS);

    assign rx_ready = ~fifoFull;
    assign fifoPush = rx_valid & rx_ready;
    assign fifoPop  = dataAccess & ~fifoEmpty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (rx_data),
        .rdata (fifoHead),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Status reflects registered occupancy, i.e. before any same-edge push.
    assign statusByte = packStatus(fifoCount, underrun_q, fifoFull, ~fifoEmpty);

    always_comb begin
        dslave_d   = dslave_q;
        underrun_d = underrun_q;
        if (dataAccess) begin
            if (fifoEmpty) begin
                dslave_d   = UNDERRUN_FILL;
                underrun_d = 1'b1;
            end else begin
                dslave_d   = fifoHead;
            end
        end else if (statusAccess) begin
            dslave_d   = statusByte;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ena_q      <= 1'b0;
            dslave_q   <= 8'h00;
            underrun_q <= 1'b0;
        end else begin
            ena_q      <= ena;
            dslave_q   <= dslave_d;
            underrun_q <= underrun_d;
        end
    end

    assign obus.dslave = dslave_q;
    assign obus.mwait  = 1'b1;

endmodule

// File: tb/tb_iport.sv
// Directed self-checking bench for iport with DEPTH=16; each task covers one
// scenario and compares the slave bus / rx_ready against hand-computed bytes.
module tb_iport;
    import z80_io_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        sel;
    Z80MasterBus ibus;
    Z80SlaveBus  obus;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    int errors;
    int checks;

    iport #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .sel      (sel),
        .ibus     (ibus),
        .obus     (obus),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // One CPU read: ena high for exactly one rising edge.
    task automatic cpuRead(input logic s, output logic [7:0] v);
        @(negedge clk);
        ena = 1'b1;
        sel = s;
        @(negedge clk);
        ena = 1'b0;
        v   = obus.dslave;
    endtask

    task automatic pushByte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obus.dslave !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dslave: got %h expected %h", obus.dslave, 8'h00);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_rx_ready: got %b expected %b", rx_ready, 1'b1);
        end
        checks++;
        if (obus.mwait !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mwait: got %b expected %b", obus.mwait, 1'b1);
        end
        rst_n = 1'b0;
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", v, 8'h00);
        end
    endtask

    task automatic test_push_pop;
        logic [7:0] v;
        pushByte(8'h41);
        pushByte(8'h42);
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h11) begin
            errors++;
            $display("[TB] FAIL status_two: got %h expected %h", v, 8'h11);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'h41) begin
            errors++;
            $display("[TB] FAIL data_first: got %h expected %h", v, 8'h41);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'h42) begin
            errors++;
            $display("[TB] FAIL data_second: got %h expected %h", v, 8'h42);
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL status_drained: got %h expected %h", v, 8'h00);
        end
    endtask

    task automatic test_underrun;
        logic [7:0] v;
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL underrun_data: got %h expected %h", v, 8'h00);
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("[TB] FAIL underrun_status: got %h expected %h", v, 8'h04);
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL underrun_cleared: got %h expected %h", v, 8'h00);
        end
    endtask

    task automatic test_full;
        logic [7:0] v;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'(i);
        end
        @(negedge clk);
        rx_data = 8'h10;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_rx_ready: got %b expected %b", rx_ready, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_stall: got %b expected %b", rx_ready, 1'b0);
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h83) begin
            errors++;
            $display("[TB] FAIL full_status: got %h expected %h", v, 8'h83);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL full_pop_data: got %h expected %h", v, 8'h00);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_ready_rise: got %b expected %b", rx_ready, 1'b1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_refilled: got %b expected %b", rx_ready, 1'b0);
        end
        for (int i = 1; i <= 16; i++) begin
            exp = 8'(i);
            cpuRead(REG_DATA, v);
            checks++;
            if (v !== exp) begin
                errors++;
                $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, v, exp);
            end
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL full_drained_status: got %h expected %h", v, 8'h00);
        end
    endtask

    task automatic test_long_ena;
        logic [7:0] v;
        pushByte(8'hA0);
        pushByte(8'hA1);
        pushByte(8'hA2);
        @(negedge clk);
        ena = 1'b1;
        sel = REG_DATA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (obus.dslave !== 8'hA0) begin
                errors++;
                $display("[TB] FAIL long_ena_hold_%0d: got %h expected %h", c, obus.dslave, 8'hA0);
            end
        end
        ena = 1'b0;
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h11) begin
            errors++;
            $display("[TB] FAIL long_ena_status: got %h expected %h", v, 8'h11);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'hA1) begin
            errors++;
            $display("[TB] FAIL long_ena_next: got %h expected %h", v, 8'hA1);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'hA2) begin
            errors++;
            $display("[TB] FAIL long_ena_last: got %h expected %h", v, 8'hA2);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        pushByte(8'h55);
        pushByte(8'h66);
        pushByte(8'h77);
        pushByte(8'h88);
        @(negedge clk);
        ena = 1'b1;
        sel = REG_DATA;
        @(negedge clk);
        checks++;
        if (obus.dslave !== 8'h55) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got %h expected %h", obus.dslave, 8'h55);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obus.dslave !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_dslave: got %h expected %h", obus.dslave, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b0;
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_status: got %h expected %h", v, 8'h00);
        end
        cpuRead(REG_DATA, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %h expected %h", v, 8'h00);
        end
        cpuRead(REG_STATUS, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("[TB] FAIL midreset_underrun: got %h expected %h", v, 8'h04);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b1;
        ena      = 1'b0;
        sel      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ibus     = '{addr: 16'h00FF, dmaster: 8'hEE, mreq_n: 1'b1, iorq_n: 1'b0,
                     rd_n: 1'b1, wr_n: 1'b0, m1_n: 1'b1};
        test_reset();
        test_push_pop();
        test_underrun();
        test_full();
        test_long_ena();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
